// File: rtl/cpu_cycle_sequencer.sv
// Instruction-cycle phase sequencer: drives fe/e1/e2 strobes, multiplier launch/wait and halt.
// Optional macro SEQ_CYCLE_COUNT_EN adds a 32-bit busy-cycle counter output (cycle_count).
module cpu_cycle_sequencer #(
  parameter int MUL_LAT  = 3,
  parameter int ICOUNT_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                run,
  input  logic                step,
  input  logic [4:0]          opcode,
  input  logic                extra1,
  output logic                fe,
  output logic                e1,
  output logic                e2,
  output logic                mul_start,
  output logic                mul_busy,
  output logic                halted,
  output logic [ICOUNT_W-1:0] instr_count
`ifdef SEQ_CYCLE_COUNT_EN
  ,
  output logic [31:0]         cycle_count
`endif
);

  localparam logic [4:0] OP_STP = 5'b00000;
  localparam logic [4:0] OP_MLR = 5'b01001;
  localparam int         CNT_W  = $clog2(MUL_LAT + 1);
  localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    EXEC1,
    MUL_WAIT,
    EXEC2,
    HALT
  } state_t;

  state_t           state, state_next;
  logic             step_mode, step_mode_next;
  logic             retire;
  logic [CNT_W-1:0] wait_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      step_mode   <= 1'b0;
      wait_cnt    <= '0;
      instr_count <= '0;
    end else begin
      state     <= state_next;
      step_mode <= step_mode_next;
      // Reload on every e1 so the wait always starts from a full count.
      if (state == EXEC1)
        wait_cnt <= WAIT_LOAD;
      else if (state == MUL_WAIT && wait_cnt != '0)
        wait_cnt <= wait_cnt - 1'b1;
      if (retire)
        instr_count <= instr_count + ICOUNT_W'(1);
    end
  end

  always_comb begin
    state_next     = state;
    step_mode_next = step_mode;
    retire         = 1'b0;
    mul_start      = 1'b0;
    case (state)
      IDLE: begin
        if (run) begin
          state_next     = FETCH;
          step_mode_next = 1'b0;
        end else if (step) begin
          state_next     = FETCH;
          step_mode_next = 1'b1;
        end
      end
      FETCH: state_next = EXEC1;
      EXEC1: begin
        if (opcode == OP_STP) begin
          state_next = HALT;
        end else if (extra1) begin
          if (opcode == OP_MLR) begin
            mul_start  = 1'b1;
            state_next = (MUL_LAT > 1) ? MUL_WAIT : EXEC2;
          end else begin
            state_next = EXEC2;
          end
        end else begin
          retire = 1'b1;
        end
      end
      MUL_WAIT: begin
        if (wait_cnt == '0)
          state_next = EXEC2;
      end
      EXEC2: retire = 1'b1;
      HALT:  state_next = HALT;
      default: state_next = IDLE;
    endcase
    // A stepped instruction always returns to IDLE, even if run rose meanwhile.
    if (retire) begin
      state_next     = (run && !step_mode) ? FETCH : IDLE;
      step_mode_next = 1'b0;
    end
  end

  assign fe       = (state == FETCH);
  assign e1       = (state == EXEC1);
  assign e2       = (state == EXEC2);
  assign mul_busy = (state == MUL_WAIT);
  assign halted   = (state == HALT);

`ifdef SEQ_CYCLE_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycle_count <= '0;
    else if (state == FETCH || state == EXEC1 || state == MUL_WAIT || state == EXEC2)
      cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule
